// File: rtl/fp32_seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential FP32 divider.
interface fp32_seq_divider_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, a, b,
    input  busy, done, result, div_by_zero, overflow, underflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/fp32_seq_divider.sv
// Iterative IEEE-754 single-precision divider, one restoring quotient bit per clock.
// Optional round-to-nearest-even (one extra guard iteration) enabled by defining FP_DIV_ROUND_EN.
module fp32_seq_divider #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned BIAS   = 127
) (
  input  logic                clk,
  input  logic                rst_n,
  fp32_seq_divider_if.slave   bus
);

  localparam int unsigned W     = 1 + EXP_W + MANT_W;
  localparam int unsigned SIG_W = MANT_W + 1;
  localparam int unsigned REM_W = MANT_W + 2;
`ifdef FP_DIV_ROUND_EN
  localparam int unsigned N_DIV = MANT_W + 3;
`else
  localparam int unsigned N_DIV = MANT_W + 2;
`endif
  localparam int unsigned Q_W       = N_DIV;
  localparam int unsigned E_W       = EXP_W + 2;
  localparam int unsigned CNT_W     = $clog2(N_DIV);
  localparam int unsigned EXP_MAX_I = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, (MANT_W-1)'(0)};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_DIVIDE = 2'd2,
    S_PACK   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sign_q, sign_d;
  logic [E_W-1:0]     exp_q, exp_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [SIG_W-1:0]   dvs_q, dvs_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               spec_q, spec_d;
  logic [W-1:0]       spec_res_q, spec_res_d;
  logic               spec_dbz_q, spec_dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  // Operand field decode, used while in SETUP
  logic [EXP_W-1:0]   ea, eb;
  logic [MANT_W-1:0]  ma, mb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               sign_c;

  always_comb begin
    ea     = a_q[W-2 -: EXP_W];
    eb     = b_q[W-2 -: EXP_W];
    ma     = a_q[MANT_W-1:0];
    mb     = b_q[MANT_W-1:0];
    sign_c = a_q[W-1] ^ b_q[W-1];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (ma == '0);
    b_inf  = (eb == EXP_ONES) && (mb == '0);
    a_nan  = (ea == EXP_ONES) && (ma != '0);
    b_nan  = (eb == EXP_ONES) && (mb != '0);
  end

  // Restoring step and pack/normalise datapath
  logic               rem_ge;
  logic [REM_W-1:0]   rem_diff;
  logic               norm;
  logic [MANT_W-1:0]  mant_t, mant_f;
  logic [E_W-1:0]     exp_t, exp_f;
`ifdef FP_DIV_ROUND_EN
  logic               guard, sticky, round_up;
  logic [MANT_W:0]    mant_sum;
`endif

  always_comb begin
    rem_ge   = (rem_q >= {1'b0, dvs_q});
    rem_diff = rem_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    norm     = quo_q[Q_W-1];
    mant_t   = norm ? quo_q[Q_W-2 -: MANT_W] : quo_q[Q_W-3 -: MANT_W];
    exp_t    = norm ? exp_q : (exp_q - E_W'(1));
`ifdef FP_DIV_ROUND_EN
    guard    = norm ? quo_q[Q_W-2-MANT_W] : quo_q[Q_W-3-MANT_W];
    sticky   = (rem_q != '0) | (norm & quo_q[0]);
    round_up = guard & (sticky | mant_t[0]);
    mant_sum = {1'b0, mant_t} + (MANT_W+1)'(round_up);
    mant_f   = mant_sum[MANT_W-1:0];
    exp_f    = exp_t + E_W'(mant_sum[MANT_W]);
`else
    mant_f   = mant_t;
    exp_f    = exp_t;
`endif
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_dbz_d = spec_dbz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !busy_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        sign_d     = sign_c;
        exp_d      = E_W'(ea) - E_W'(eb) + E_W'(BIAS);
        rem_d      = {1'b0, 1'b1, ma};
        dvs_d      = {1'b1, mb};
        quo_d      = '0;
        cnt_d      = '0;
        spec_d     = 1'b1;
        spec_dbz_d = 1'b0;
        spec_res_d = '0;
        // Special-value priority: NaN-producing, x/0, inf/x, then zero results
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_res_d = QNAN;
        end else if (b_zero && !a_inf) begin
          spec_res_d = {sign_c, EXP_ONES, MANT_W'(0)};
          spec_dbz_d = 1'b1;
        end else if (a_inf) begin
          spec_res_d = {sign_c, EXP_ONES, MANT_W'(0)};
        end else if (b_inf || a_zero) begin
          spec_res_d = {sign_c, (W-1)'(0)};
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_DIVIDE;
      end

      S_DIVIDE: begin
        rem_d = {rem_diff[REM_W-2:0], 1'b0};
        quo_d = {quo_q[Q_W-2:0], rem_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_DIV - 1)) begin
          state_d = S_PACK;
        end
      end

      S_PACK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (spec_q) begin
          result_d = spec_res_q;
          dbz_d    = spec_dbz_q;
        end else if (!exp_f[E_W-1] && (exp_f >= E_W'(EXP_MAX_I))) begin
          result_d = {sign_q, EXP_ONES, MANT_W'(0)};
          ovf_d    = 1'b1;
        end else if (exp_f[E_W-1] || (exp_f == '0)) begin
          result_d = {sign_q, (W-1)'(0)};
          udf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_f[EXP_W-1:0], mant_f};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_dbz_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_dbz_q <= spec_dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;

endmodule
